// File: rtl/avg_pool_accumulator.sv
// avg_pool_accumulator
// Streaming window accumulator for the average-pooling path. Sums
// 2^WINDOW_LOG2 signed fixed-point elements at widened precision, then divides
// by the window size with an arithmetic shift. Emits one registered result per
// window over a valid/ready output.
//
// Optional feature macro: AVG_POOL_ROUND_EN
//   defined   -> add 2^(WINDOW_LOG2-1) before the shift (round half up)
//   undefined -> plain arithmetic shift (floor toward -inf)
module avg_pool_accumulator #(
    parameter int DATA_WIDTH  = 16,
    parameter int E           = 6,
    parameter int M           = 10,
    parameter int WINDOW_LOG2 = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WINDOW_LOG2-1:0] elem_count
);

    // Sum of 2^WINDOW_LOG2 signed words needs WINDOW_LOG2 extra bits.
    localparam int ACC_WIDTH = DATA_WIDTH + WINDOW_LOG2;
    localparam logic [WINDOW_LOG2-1:0] LAST_COUNT = '1;

`ifdef AVG_POOL_ROUND_EN
    // Half of the divisor, so the shift rounds half up instead of flooring.
    localparam logic [ACC_WIDTH-1:0] ROUND_BIAS =
        {{(ACC_WIDTH-1){1'b0}}, 1'b1} << (WINDOW_LOG2 - 1);
`else
    localparam logic [ACC_WIDTH-1:0] ROUND_BIAS = '0;
`endif

    // Elaboration-time sanity on the fixed-point format and window size.
    if (E + M != DATA_WIDTH) begin : g_bad_format
        $error("avg_pool_accumulator: E + M must equal DATA_WIDTH");
    end
    if (WINDOW_LOG2 < 1) begin : g_bad_window
        $error("avg_pool_accumulator: WINDOW_LOG2 must be at least 1");
    end

    logic [ACC_WIDTH-1:0]  r_acc;
    logic [WINDOW_LOG2-1:0] r_elem_count;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic                  r_out_valid;

    logic [ACC_WIDTH-1:0]  w_in_ext;
    logic [ACC_WIDTH-1:0]  w_sum;
    logic [ACC_WIDTH-1:0]  w_biased;
    logic [DATA_WIDTH-1:0] w_avg;
    logic                  w_last;
    logic                  w_accept;
    logic                  w_unused_frac;

    // Sign-extend the incoming element to accumulator width.
    assign w_in_ext[DATA_WIDTH-1:0] = in_data;
    for (genvar gi = DATA_WIDTH; gi < ACC_WIDTH; gi++) begin : g_sign_ext
        assign w_in_ext[gi] = in_data[DATA_WIDTH-1];
    end

    // The completing element is folded into the sum in the same cycle.
    assign w_sum    = r_acc + w_in_ext;
    assign w_biased = w_sum + ROUND_BIAS;

    // Arithmetic shift right by WINDOW_LOG2, keeping the low DATA_WIDTH bits:
    // that is exactly the upper DATA_WIDTH bits of the widened sum.
    assign w_avg         = w_biased[ACC_WIDTH-1:WINDOW_LOG2];
    assign w_unused_frac = ^w_biased[WINDOW_LOG2-1:0];

    // Only the window-completing element waits on a stalled result.
    assign w_last   = (r_elem_count == LAST_COUNT);
    assign in_ready = !(w_last && r_out_valid && !out_ready);
    assign w_accept = in_valid && in_ready;

    assign out_data   = r_out_data;
    assign out_valid  = r_out_valid;
    assign elem_count = r_elem_count;

    // Accumulate accepted elements and register one average per window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc        <= '0;
            r_elem_count <= '0;
            r_out_data   <= '0;
            r_out_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_last) begin
                    r_acc        <= '0;
                    r_elem_count <= '0;
                    r_out_data   <= w_avg;
                end else begin
                    r_acc        <= w_sum;
                    r_elem_count <= r_elem_count + 1'b1;
                end
            end
            // A new result wins over a consumed one, so there is no bubble.
            if (w_accept && w_last) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avg_pool_accumulator.sv
// Self-checking bench for avg_pool_accumulator (default parameters).
// Expected averages come from an integer reference model and are queued when
// the last element of a window is accepted, then popped on output handshake.
module tb_avg_pool_accumulator;

    localparam int WL = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  elem_count;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] exp_q[$];
    int          m_sum = 0;
    int          m_cnt = 0;

    avg_pool_accumulator dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .elem_count (elem_count)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_avg(input int s);
        int t;
        t = s;
`ifdef AVG_POOL_ROUND_EN
        t = t + (1 << (WL - 1));
`endif
        t = t >>> WL;
        return t[15:0];
    endfunction

    function automatic void model_accept(input logic [15:0] d);
        m_sum = m_sum + int'($signed(d));
        if (m_cnt == (1 << WL) - 1) begin
            exp_q.push_back(exp_avg(m_sum));
            m_sum = 0;
            m_cnt = 0;
        end else begin
            m_cnt = m_cnt + 1;
        end
    endfunction

    function automatic void model_clear();
        m_sum = 0;
        m_cnt = 0;
        exp_q.delete();
    endfunction

    // Drive one cycle of inputs; sample outputs on the falling edge.
    task automatic step(input logic v, input logic [15:0] d, input logic r,
                        output logic acc, output logic hs, output logic [15:0] od,
                        output logic ov, output logic ir, output logic [1:0] ec);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        @(negedge clk);
        ir  = in_ready;
        ov  = out_valid;
        od  = out_data;
        ec  = elem_count;
        acc = v && ir;
        hs  = ov && r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        checks++;
        if (out_data !== 16'h0000) begin
            failures++; $display("FAIL reset_out_data: got %h expected 0000", out_data);
        end
        checks++;
        if (elem_count !== 2'd0) begin
            failures++; $display("FAIL reset_elem_count: got %0d expected 0", elem_count);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        @(posedge clk);
        #1;
        model_clear();
        $display("test_reset done");
    endtask

    // Directed windows: sum/average, negatives, full scale, rounding corners.
    task automatic test_windows();
        logic [15:0] tab [5][4];
        logic acc, hs, ov, ir;
        logic [15:0] od, e;
        logic [1:0] ec;
        tab[0] = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000};
        tab[1] = '{16'hFC00, 16'hFC00, 16'hFC00, 16'hFC00};
        tab[2] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        tab[3] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000};
        tab[4] = '{16'hFFFF, 16'h0000, 16'h0000, 16'h0000};
        for (int w = 0; w < 5; w++) begin
            for (int i = 0; i < 4; i++) begin
                step(1'b1, tab[w][i], 1'b1, acc, hs, od, ov, ir, ec);
                checks++;
                if (acc !== 1'b1 || ec !== 2'(i)) begin
                    failures++;
                    $display("FAIL win%0d_accept%0d: got acc=%b cnt=%0d expected acc=1 cnt=%0d",
                             w, i, acc, ec, i);
                end
                checks++;
                if (ov !== 1'b0) begin
                    failures++; $display("FAIL win%0d_early_valid%0d: got %b expected 0", w, i, ov);
                end
                if (acc) model_accept(tab[w][i]);
            end
            step(1'b0, 16'h0000, 1'b1, acc, hs, od, ov, ir, ec);
            checks++;
            if (ov !== 1'b1) begin
                failures++; $display("FAIL win%0d_latency: got out_valid=%b expected 1", w, ov);
            end
            if (hs && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (od !== e) begin
                    failures++; $display("FAIL win%0d_data: got %h expected %h", w, od, e);
                end
            end
            step(1'b0, 16'h0000, 1'b1, acc, hs, od, ov, ir, ec);
            checks++;
            if (ov !== 1'b0 || exp_q.size() != 0) begin
                failures++;
                $display("FAIL win%0d_pulse: got out_valid=%b pending=%0d expected 0 0",
                         w, ov, exp_q.size());
            end
            $display("test_windows window %0d done", w);
        end
    endtask

    // Stalled output: next window fills except its last element.
    task automatic test_backpressure();
        logic acc, hs, ov, ir;
        logic [15:0] od, e, held;
        logic [1:0] ec;
        logic [15:0] d [8];
        d = '{16'h0400, 16'h0400, 16'h0800, 16'h0800, 16'hF000, 16'h0200, 16'h0100, 16'h0300};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d[i], 1'b0, acc, hs, od, ov, ir, ec);
            if (acc) model_accept(d[i]);
        end
        held = (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx;
        for (int i = 4; i < 7; i++) begin
            step(1'b1, d[i], 1'b0, acc, hs, od, ov, ir, ec);
            checks++;
            if (acc !== 1'b1 || ov !== 1'b1 || od !== held) begin
                failures++;
                $display("FAIL bp_stall_accept%0d: got acc=%b ov=%b data=%h expected 1 1 %h",
                         i, acc, ov, od, held);
            end
            if (acc) model_accept(d[i]);
        end
        for (int k = 0; k < 3; k++) begin
            step(1'b1, d[7], 1'b0, acc, hs, od, ov, ir, ec);
            checks++;
            if (ir !== 1'b0 || ec !== 2'd3 || od !== held || ov !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold%0d: got ready=%b cnt=%0d data=%h ov=%b expected 0 3 %h 1",
                         k, ir, ec, od, ov, held);
            end
            if (acc) model_accept(d[7]);
        end
        step(1'b1, d[7], 1'b1, acc, hs, od, ov, ir, ec);
        checks++;
        if (ir !== 1'b1 || hs !== 1'b1) begin
            failures++; $display("FAIL bp_release: got ready=%b handshake=%b expected 1 1", ir, hs);
        end
        if (hs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (od !== e) begin
                failures++; $display("FAIL bp_first_data: got %h expected %h", od, e);
            end
        end
        if (acc) model_accept(d[7]);
        step(1'b0, 16'h0000, 1'b1, acc, hs, od, ov, ir, ec);
        checks++;
        if (ov !== 1'b1) begin
            failures++; $display("FAIL bp_second_valid: got %b expected 1", ov);
        end
        if (hs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (od !== e) begin
                failures++; $display("FAIL bp_second_data: got %h expected %h", od, e);
            end
        end
        step(1'b0, 16'h0000, 1'b1, acc, hs, od, ov, ir, ec);
        checks++;
        if (ov !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_drain: got ov=%b pending=%0d expected 0 0", ov, exp_q.size());
        end
        $display("test_backpressure done");
    endtask

    // Reset mid-window with a pending result; nothing may leak afterwards.
    task automatic test_reset_mid_window();
        logic acc, hs, ov, ir;
        logic [15:0] od, e;
        logic [1:0] ec;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0100, 1'b0, acc, hs, od, ov, ir, ec);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 16'h7000, 1'b0, acc, hs, od, ov, ir, ec);
        end
        in_valid = 1'b0;
        reset = 1'b1;
        #2;
        checks++;
        if (elem_count !== 2'd0 || out_valid !== 1'b0 || out_data !== 16'h0000) begin
            failures++;
            $display("FAIL rst_async: got cnt=%0d ov=%b data=%h expected 0 0 0000",
                     elem_count, out_valid, out_data);
        end
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 16'h0400, 1'b1, acc, hs, od, ov, ir, ec);
            checks++;
            if (acc !== 1'b1 || ec !== 2'(i)) begin
                failures++;
                $display("FAIL rst_refill%0d: got acc=%b cnt=%0d expected 1 %0d", i, acc, ec, i);
            end
            if (acc) model_accept(16'h0400);
        end
        step(1'b0, 16'h0000, 1'b1, acc, hs, od, ov, ir, ec);
        checks++;
        if (ov !== 1'b1) begin
            failures++; $display("FAIL rst_result_valid: got %b expected 1", ov);
        end
        if (hs && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (od !== e || od !== 16'h0400) begin
                failures++; $display("FAIL rst_result_data: got %h expected %h", od, e);
            end
        end
        step(1'b0, 16'h0000, 1'b1, acc, hs, od, ov, ir, ec);
        $display("test_reset_mid_window done");
    endtask

    // Random in_valid/out_ready traffic over 1000 windows.
    task automatic test_random();
        logic acc, hs, ov, ir, v, r;
        logic [15:0] od, e, d;
        logic [1:0] ec;
        int accepted, results, cycles;
        logic exp_ready;
        accepted = 0;
        results = 0;
        cycles = 0;
        while ((accepted < 4000 || exp_q.size() > 0) && cycles < 40000) begin
            v = (accepted < 4000) ? ($urandom_range(0, 3) != 0) : 1'b0;
            r = ($urandom_range(0, 3) != 0) || (accepted >= 4000);
            d = 16'($urandom);
            exp_ready = !(m_cnt == 3 && exp_q.size() > 0 && !r);
            step(v, d, r, acc, hs, od, ov, ir, ec);
            cycles++;
            checks++;
            if (ir !== exp_ready || ov !== (exp_q.size() > 0) || ec !== 2'(m_cnt)) begin
                failures++;
                $display("FAIL rand_ctrl cyc%0d: got ready=%b ov=%b cnt=%0d expected %b %b %0d",
                         cycles, ir, ov, ec, exp_ready, exp_q.size() > 0, m_cnt);
            end
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rand_extra cyc%0d: got result %h expected none", cycles, od);
                end else begin
                    e = exp_q.pop_front();
                    results++;
                    checks++;
                    if (od !== e) begin
                        failures++;
                        $display("FAIL rand_data win%0d: got %h expected %h", results, od, e);
                    end
                end
            end
            if (acc) begin
                accepted++;
                model_accept(d);
            end
        end
        checks++;
        if (results != 1000 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rand_count: got results=%0d pending=%0d expected 1000 0",
                     results, exp_q.size());
        end
        $display("test_random done results=%0d cycles=%0d", results, cycles);
    endtask

    initial begin
        test_reset();
        test_windows();
        test_backpressure();
        test_reset_mid_window();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
